// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: decimates offset-binary ADC words into signed frames and streams them out over valid/ready.
// Define ADC_FRAME_OVERRUN_CNT_EN to count ticks dropped while a frame drains.
module adc_frame_buffer #(
  parameter int DATA_W = 12,
  parameter int FRAME_LEN = 256,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              ENABLE,
  output logic [DATA_W-1:0] SAMPLE_OUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_FIRST,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic [15:0]       OVERRUN_CNT
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(SAMPLE_DIV);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] mem [FRAME_LEN];
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] rd_cnt;
  logic tick, wr_en, wr_end, rd_en, more, xfer_last;
  assign tick = cnt == CW'(SAMPLE_DIV - 1);
  assign wr_en = state == FILL && ENABLE && tick;
  assign wr_end = wr_en && wr_ptr == AW'(FRAME_LEN - 1);
  assign more = state == DRAIN && !rd_cnt[AW];
  // the RAM read register doubles as the output register, so a stall simply freezes it
  assign rd_en = !OUT_VALID || OUT_READY;
  assign xfer_last = OUT_VALID && OUT_READY && OUT_LAST;
  assign BUSY = state != IDLE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = ENABLE ? FILL : IDLE;
      FILL:    state_nx = !ENABLE ? IDLE : wr_end ? DRAIN : FILL;
      DRAIN:   state_nx = !xfer_last ? DRAIN : ENABLE ? FILL : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50)
    if (wr_en) mem[wr_ptr] <= {~din_q[DATA_W-1], din_q[DATA_W-2:0]};
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
      din_q <= '0;
      cnt <= '0;
      wr_ptr <= '0;
      rd_cnt <= '0;
      SAMPLE_OUT <= '0;
      OUT_VALID <= 1'b0;
      OUT_FIRST <= 1'b0;
      OUT_LAST <= 1'b0;
    end else begin
      state <= state_nx;
      din_q <= DATA_IN;
      cnt <= tick ? '0 : cnt + 1'b1;
      wr_ptr <= (state == FILL && ENABLE) ? wr_ptr + AW'(tick) : '0;
      if (rd_en) begin
        OUT_VALID <= more;
        OUT_FIRST <= more && rd_cnt == '0;
        OUT_LAST <= more && rd_cnt == (AW+1)'(FRAME_LEN - 1);
        if (more) begin
          SAMPLE_OUT <= mem[rd_cnt[AW-1:0]];
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
      if (xfer_last) rd_cnt <= '0;
    end
  end
`ifdef ADC_FRAME_OVERRUN_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) OVERRUN_CNT <= '0;
    else if (tick && state == DRAIN && OVERRUN_CNT != 16'hFFFF) OVERRUN_CNT <= OVERRUN_CNT + 1'b1;
  end
`else
  assign OVERRUN_CNT = '0;
`endif
endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer: random stimulus against a queue-based frame model of adc_frame_buffer.
module tb_adc_frame_buffer;
  localparam int DW = 12;
  localparam int FL = 8;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst, enable, ready, valid, first, last, busy;
  logic [DW-1:0] data_in, sample_out, din_prev, cval;
  logic [15:0] ovf;
  int errors = 0, checks = 0;
  int k, mode, drain_start, last_tick_k, vrise_k, last_k, stall_left, data_mode, ready_mode, ovf_exp;
  logic [DW-1:0] cap[$], pend[$], rx[$];
  bit got_last, prev_v;
  always #10 clk = ~clk;
  adc_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FL), .SAMPLE_DIV(SD)) dut (
    .CLOCK_50(clk), .RESET(rst), .DATA_IN(data_in), .ENABLE(enable),
    .SAMPLE_OUT(sample_out), .OUT_VALID(valid), .OUT_READY(ready),
    .OUT_FIRST(first), .OUT_LAST(last), .BUSY(busy), .OVERRUN_CNT(ovf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
    return d - DW'(1 << (DW - 1));
  endfunction
  // one clock cycle: drive inputs, compare outputs with the model, advance the model, step the clock
  task automatic cyc();
    bit tick, vexp;
    int idx;
    data_in = (data_mode == 0) ? DW'(2048 + cap.size()) : (data_mode == 1) ? cval : DW'($urandom);
    if (stall_left > 0) begin
      ready = 1'b0;
      stall_left--;
    end else ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    vexp = mode == 2 && k >= drain_start && pend.size() > 0;
    idx = FL - pend.size();
    check("valid", valid, vexp);
    check("busy", busy, mode != 0);
`ifdef ADC_FRAME_OVERRUN_CNT_EN
    check("overrun", ovf, ovf_exp);
`else
    check("overrun", ovf, 0);
`endif
    if (vexp) begin
      check("data", sample_out, pend[0]);
      check("first", first, idx == 0);
      check("last", last, idx == FL - 1);
    end
    if (valid && !prev_v) vrise_k = k;
    prev_v = valid;
    if (valid && ready) begin
      rx.push_back(sample_out);
      if (last) begin
        got_last = 1;
        last_k = k;
      end
    end
    tick = (k % SD) == SD - 1;
    if (rst) begin
      mode = 0;
      cap.delete();
      pend.delete();
      ovf_exp = 0;
      k = 0;
      din_prev = '0;
    end else begin
      case (mode)
        0: if (enable) mode = 1;
        1: if (!enable) begin
             mode = 0;
             cap.delete();
           end else if (tick) begin
             cap.push_back(conv(din_prev));
             if (cap.size() == FL) begin
               pend = cap;
               cap.delete();
               mode = 2;
               drain_start = k + 2;
               last_tick_k = k;
             end
           end
        default: begin
          if (tick) ovf_exp++;
          if (vexp && ready) begin
            void'(pend.pop_front());
            if (pend.size() == 0) mode = enable ? 1 : 0;
          end
        end
      endcase
      din_prev = data_in;
      k++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_last(input int budget);
    int n = 0;
    got_last = 0;
    while (!got_last && n < budget) begin
      cyc();
      n++;
    end
    check("frame_done", got_last, 1);
  endtask
  task automatic wait_valid(input int budget);
    int n = 0;
    while (!valid && n < budget) begin
      cyc();
      n++;
    end
    check("valid_seen", valid, 1);
  endtask
  task automatic wait_rx(input int cnt, input int budget);
    int n = 0;
    while (rx.size() < cnt && n < budget) begin
      cyc();
      n++;
    end
    check("rx_progress", rx.size(), cnt);
  endtask
  task automatic check_ramp();
    check("rx_len", rx.size(), FL);
    foreach (rx[i]) check("rx_seq", rx[i], i);
  endtask
  task automatic restart();
    enable = 1'b0;
    cyc();
    cyc();
    enable = 1'b1;
    rx.delete();
  endtask
  initial begin
    logic [DW-1:0] cin [3];
    logic [DW-1:0] cexp [3];
    cin = '{12'h000, 12'hFFF, 12'h800};
    cexp = '{12'h800, 12'h7FF, 12'h000};
    data_mode = 0;
    ready_mode = 0;
    stall_left = 0;
    cval = '0;
    data_in = '0;
    rst = 1'b1;
    enable = 1'b0;
    ready = 1'b1;
    prev_v = 0;
    drain_start = 0;
    last_tick_k = 0;
    vrise_k = 0;
    last_k = 0;
    repeat (2) @(posedge clk);
    #1;
    mode = 0;
    k = 0;
    ovf_exp = 0;
    din_prev = '0;
    check("rst_valid", valid, 0);
    check("rst_data", sample_out, 0);
    check("rst_first", first, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    // ramp frame with READY high: latency and back-to-back burst
    enable = 1'b1;
    rx.delete();
    wait_last(400);
    check_ramp();
    check("latency", vrise_k - last_tick_k, 2);
    check("burst", last_k - vrise_k, FL - 1);
    // constant-input frames at the conversion extremes
    for (int c = 0; c < 3; c++) begin
      data_mode = 1;
      cval = cin[c];
      restart();
      wait_last(400);
      check("const_len", rx.size(), FL);
      foreach (rx[i]) check("const_val", rx[i], cexp[c]);
    end
    // mid-drain stall, then random READY
    data_mode = 0;
    restart();
    wait_rx(3, 400);
    stall_left = 10;
    ready_mode = 1;
    wait_last(400);
    check_ramp();
    ready_mode = 0;
    // long stall from VALID rise forces overruns; following frame must be intact
    restart();
    wait_valid(400);
    stall_left = 13;
    wait_last(400);
    check_ramp();
    rx.delete();
    wait_last(400);
    check_ramp();
    // abort a partial fill, then capture a fresh frame
    restart();
    begin
      int n = 0;
      while (cap.size() < 3 && n < 400) begin
        cyc();
        n++;
      end
    end
    enable = 1'b0;
    cyc();
    check("abort_busy", busy, 0);
    repeat (12) cyc();
    check("abort_no_out", rx.size(), 0);
    enable = 1'b1;
    wait_last(400);
    check_ramp();
    // reset while a frame is being emitted
    data_mode = 2;
    restart();
    wait_valid(400);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data", sample_out, 0);
    check("mid_rst_first", first, 0);
    check("mid_rst_last", last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf, 0);
    // random data with random READY
    ready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      rx.delete();
      wait_last(600);
      check("rand_len", rx.size(), FL);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
